// File: rtl/mono_pixel_packer.sv
// mono_pixel_packer: packs 1-bpp pixels MSB-first into addressed framebuffer words
// and queues them (2 deep) as valid/ready write requests with sticky drop reporting.
module mono_pixel_packer #(
    parameter int WORD_W   = 16,
    parameter int H_ACTIVE = 512,
    parameter int V_ACTIVE = 342,
    parameter int ADDR_W   = 14,
    parameter int INVERT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mono_in,
    input  logic              sof,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              overflow,
    output logic              frame_done
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int BW = $clog2(WORD_W);
    localparam int PW = $clog2(TOTAL + 1);
    localparam logic INV = (INVERT != 0);

    logic [BW-1:0]     bit_q, bit_d, bc;
    logic [WORD_W-1:0] shift_q, shift_d, sh, word;
    logic [ADDR_W-1:0] addr_q, addr_d, ad;
    logic [PW-1:0]     pix_q, pix_d, pc;
    logic              armed_q, armed_d, arm;
    logic              overflow_q, overflow_d, frame_done_q, frame_done_d;
    logic [1:0]        cnt_q, cnt_d, slot;
    logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d;
    logic [WORD_W-1:0] d0_q, d0_d, d1_q, d1_d;
    logic              acc, wdone, last, pop, push;

    assign wr_valid   = (cnt_q != 2'd0);
    assign wr_addr    = a0_q;
    assign wr_data    = d0_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

    always_comb begin
        // sof restarts the frame in the same cycle, so it overrides the current counters
        bc    = sof ? '0 : bit_q;
        sh    = sof ? '0 : shift_q;
        ad    = sof ? '0 : addr_q;
        pc    = sof ? '0 : pix_q;
        arm   = sof | armed_q;
        acc   = enable & arm;
        word  = {sh[WORD_W-2:0], mono_in ^ INV};
        wdone = acc && (bc == BW'(WORD_W - 1));
        last  = acc && (pc == PW'(TOTAL - 1));
        pop   = wr_valid & wr_ready;
        push  = wdone && (cnt_q != 2'd2 || pop);
        slot  = cnt_q - {1'b0, pop};
        bit_d        = acc ? (wdone ? '0 : bc + 1'b1) : bc;
        shift_d      = acc ? word : sh;
        addr_d       = wdone ? ad + 1'b1 : ad;
        pix_d        = acc ? pc + 1'b1 : pc;
        armed_d      = arm & ~last;
        overflow_d   = (overflow_q & ~sof) | (wdone & ~push);
        frame_done_d = last;
        cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};
        // the head shifts forward on pop; the new word lands in the first free slot
        a0_d = (push && slot == 2'd0) ? ad : (pop ? a1_q : a0_q);
        d0_d = (push && slot == 2'd0) ? word : (pop ? d1_q : d0_q);
        a1_d = (push && slot == 2'd1) ? ad : a1_q;
        d1_d = (push && slot == 2'd1) ? word : d1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q        <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            pix_q        <= '0;
            armed_q      <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            a0_q         <= '0;
            a1_q         <= '0;
            d0_q         <= '0;
            d1_q         <= '0;
        end else begin
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            pix_q        <= pix_d;
            armed_q      <= armed_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            a0_q         <= a0_d;
            a1_q         <= a1_d;
            d0_q         <= d0_d;
            d1_q         <= d1_d;
        end
    end
endmodule

// File: tb/tb_mono_pixel_packer.sv
// tb_mono_pixel_packer: directed and random stimulus against a queue-based reference model.
module tb_mono_pixel_packer;
    localparam int W = 16, H = 64, V = 6, TOT = H * V, NW = TOT / W;

    logic clk = 1'b0;
    logic reset, enable, mono_in, sof, wr_ready;
    logic wr_valid, overflow, frame_done;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic iv_valid, iv_ovf, iv_done;
    logic [13:0] iv_addr;
    logic [15:0] iv_data;

    mono_pixel_packer #(.WORD_W(W), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(14), .INVERT(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mono_in(mono_in), .sof(sof),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .overflow(overflow), .frame_done(frame_done));

    mono_pixel_packer #(.INVERT(1)) dut_inv (
        .clk(clk), .reset(reset), .enable(enable), .mono_in(mono_in), .sof(sof),
        .wr_valid(iv_valid), .wr_ready(1'b1), .wr_addr(iv_addr), .wr_data(iv_data),
        .overflow(iv_ovf), .frame_done(iv_done));

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t mq[$];
    int checks = 0, errors = 0;
    int m_pix, m_bits, m_word, m_addr, n_pop, last_pop_addr, n_done;
    bit m_armed, m_ovf, m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pix = 0; m_bits = 0; m_word = 0; m_addr = 0;
        m_armed = 0; m_ovf = 0; m_done = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare everything observable.
    task automatic step(input logic en, input logic px, input logic s, input logic rdy);
        bit popped;
        ent_t e;
        enable = en; mono_in = px; sof = s; wr_ready = rdy;
        @(posedge clk);
        popped = rdy && mq.size() > 0;
        m_done = 0;
        if (s) begin
            m_pix = 0; m_bits = 0; m_word = 0; m_addr = 0; m_ovf = 0; m_armed = 1;
        end
        if (popped) begin
            n_pop++;
            last_pop_addr = int'(mq[0].a);
            void'(mq.pop_front());
        end
        if (en && m_armed) begin
            m_word = m_word * 2 + int'(px);
            m_bits++;
            m_pix++;
            if (m_bits == W) begin
                e.a = 14'(m_addr);
                e.d = 16'(m_word);
                if (mq.size() < 2) mq.push_back(e);
                else m_ovf = 1;
                m_addr++; m_bits = 0; m_word = 0;
            end
            if (m_pix == TOT) begin
                m_done = 1;
                m_armed = 0;
            end
        end
        #1;
        chk("wr_valid", 32'(wr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(mq[0].a));
            chk("wr_data", 32'(wr_data), 32'(mq[0].d));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        if (frame_done) n_done++;
    endtask

    task automatic feed_word(input logic [15:0] w, input logic rdy);
        for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, rdy);
    endtask

    initial begin
        reset = 1'b1; enable = 0; mono_in = 0; sof = 0; wr_ready = 0;
        n_pop = 0; last_pop_addr = -1; n_done = 0;
        model_reset();
        #12;
        chk("rst_valid", 32'(wr_valid), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        reset = 1'b0;

        // pattern words with the writer always ready
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed_word(16'hAAAA, 1'b1);
        chk("t1_addr0", 32'(wr_addr), 32'h0);
        chk("t1_data0", 32'(wr_data), 32'hAAAA);
        feed_word(16'hFFFF, 1'b1);
        chk("t1_addr1", 32'(wr_addr), 32'h1);
        chk("t1_data1", 32'(wr_data), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_drain", 32'(wr_valid), 0);

        // stalled writer: third word is dropped
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(16'h0001, 1'b0);
        feed_word(16'h0002, 1'b0);
        feed_word(16'h0003, 1'b0);
        chk("t2_overflow", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_hold_addr", 32'(wr_addr), 32'h0);
        chk("t2_hold_data", 32'(wr_data), 32'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_next_addr", 32'(wr_addr), 32'h1);
        chk("t2_next_data", 32'(wr_data), 32'h0002);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_empty", 32'(wr_valid), 0);

        // sof discards a partial word and clears overflow
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_ovf_clr", 32'(overflow), 0);
        feed_word(16'hFFFF, 1'b1);
        chk("t3_addr", 32'(wr_addr), 32'h0);
        chk("t3_data", 32'(wr_data), 32'hFFFF);

        // inverted instance stores ~mono_in
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed_word(16'h0000, 1'b1);
        chk("t5_inv_valid", 32'(iv_valid), 1);
        chk("t5_inv_data", 32'(iv_data), 32'hFFFF);
        chk("t5_plain_data", 32'(wr_data), 32'h0000);

        // full frame with random enable gaps, then trailing pixels ignored
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_pop = 0; n_done = 0;
        for (int c = 0; c < 4 * TOT && m_pix < TOT; c++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 1'b1);
        chk("t4_frame_len", 32'(m_pix), 32'(TOT));
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1);
        chk("t4_writes", 32'(n_pop), 32'(NW));
        chk("t4_last_addr", 32'(last_pop_addr), 32'(NW - 1));
        chk("t4_done_pulses", 32'(n_done), 1);

        // random mix of stalls, gaps and restarts
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 2) != 0));

        // asynchronous reset with two queued entries and a partial word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed_word(16'h1234, 1'b0);
        feed_word(16'h5678, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_queued", 32'(wr_valid), 1);
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(wr_valid), 0);
        chk("t6_async_addr", 32'(wr_addr), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6_unarmed", 32'(wr_valid), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        feed_word(16'hC3C3, 1'b1);
        chk("t6_addr", 32'(wr_addr), 32'h0);
        chk("t6_data", 32'(wr_data), 32'hC3C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mono_pixel_packer.md
# mono_pixel_packer

Packs the 1-bit-per-pixel stream produced by the colour-to-mono threshold stage into framebuffer words and issues valid/ready write requests to the Mac SE framebuffer writer. Sits directly downstream of the colour converter: consumes its `mono_out` plus the pixel `enable` strobe and frame-start marker, and produces addressed words. Holds the words in a 2-entry output queue to absorb short write stalls. Reports dropped words through a sticky overflow flag.

## Interface
- `WORD_W`, 16, pixels per framebuffer word (power of two, 8..32)
- `H_ACTIVE`, 512, active pixels per line (multiple of `WORD_W`)
- `V_ACTIVE`, 342, active lines per frame
- `ADDR_W`, 14, word-address width (must hold `H_ACTIVE*V_ACTIVE/WORD_W - 1`)
- `INVERT`, 0, 1 = store `~mono_in` (Mac SE black = 1)

- `clk`  in  1  pixel clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `enable`  in  1  `mono_in` holds a valid pixel this cycle
- `mono_in`  in  1  pixel value from the colour converter
- `sof`  in  1  start of frame; sampled every cycle
- `wr_valid`  out  1  head of the output queue is valid
- `wr_ready`  in  1  writer accepts the head this cycle
- `wr_addr`  out  `ADDR_W`  word address of the head entry
- `wr_data`  out  `WORD_W`  packed pixels of the head entry
- `overflow`  out  1  sticky: at least one word dropped this frame
- `frame_done`  out  1  one-cycle pulse: last pixel of the frame accepted

## Operation
- Pixel accepted when `enable`=1 and the frame is not complete. Pixels after the frame completes are ignored until `sof`.
- Packing is MSB-first: the first pixel of each word goes to bit `WORD_W-1`, and the last pixel to bit 0. Stored bit = `mono_in ^ INVERT`.
- Bit counter 0..`WORD_W-1`. The word is complete when the `WORD_W`-th pixel is accepted; the counter then returns to 0.
- Word address counter starts at 0 and increments by 1 per completed word, linear across lines (address = line*`H_ACTIVE/WORD_W` + column word).
- Frame completes after `H_ACTIVE*V_ACTIVE` accepted pixels, with the final address at `H_ACTIVE*V_ACTIVE/WORD_W - 1`.
- `sof`=1 discards any partial word and resets the bit counter, address and pixel count to 0. It also clears `overflow` and re-arms the frame.
  - If `enable`=1 in the same cycle, that pixel is pixel 0 of the new frame.
  - `sof` does not flush words already in the queue.
- Output queue: 2-entry FIFO of {addr, data}. A completed word is pushed into it.
  - Push is refused only when the queue holds 2 entries and no pop occurs in the same cycle. A refused word is dropped, the address still advances, and `overflow` is set to 1.
- Pop occurs when `wr_valid`=1 and `wr_ready`=1.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `overflow`=0, `frame_done`=0. The queue is empty, and the bit, address and pixel counters are 0.
- Latency: a word completed at edge N (queue empty) drives `wr_valid`=1 with its addr/data after edge N, i.e. visible in cycle N+1.
- While `wr_valid`=1 and `wr_ready`=0, `wr_valid`, `wr_addr` and `wr_data` hold stable.
- When the head is popped, the next entry (if any) appears in the following cycle with no bubble. `wr_valid` drops the cycle after the last pop.
- `frame_done` is high for exactly one cycle, the cycle after the final pixel of the frame is accepted, whether or not the final word was dropped.
- `overflow` rises the cycle after the drop and stays high until `sof` or `reset`.
- `reset` asserted mid-frame: all outputs take reset values immediately (asynchronously). Queued words are lost, and the next frame requires `sof`.
- `enable` gaps of any length do not disturb the packing state.

## Test plan
- After `sof`, 16 pixels 1,0,1,0,… with `wr_ready`=1 -> one cycle later `wr_valid`=1, `wr_addr`=0, `wr_data`=16'hAAAA; next 16 pixels all 1 -> `wr_addr`=1, `wr_data`=16'hFFFF.
- `wr_ready`=0 while 3 words (16'h0001, 16'h0002, 16'h0003) complete -> `overflow`=1 after the third. Releasing `wr_ready` yields exactly addr 0/16'h0001 then addr 1/16'h0002, with the outputs held stable during the stall.
- `sof` after 5 pixels, then 16 pixels of 1 -> a single word, `wr_addr`=0, `wr_data`=16'hFFFF (partial discarded); `overflow` cleared.
- Full frame of 175104 pixels with random `enable` gaps and `wr_ready`=1 -> 10944 writes, addresses 0..10943 in order; `frame_done` pulses once, one cycle after the last pixel; further pixels produce no writes.
- `INVERT`=1, 16 pixels of 0 -> `wr_data`=16'hFFFF.
- `reset` asserted mid-word with 2 entries queued -> `wr_valid`=0 immediately. After `sof` and 16 pixels, the first write has `wr_addr`=0.
